// File: rtl/can_pkg.sv
// Shared types and default field widths for the CAN bit-timing block.
package can_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StSeg1,
    StSeg2
  } can_state_e;

  localparam int unsigned BrpWDefault   = 8;
  localparam int unsigned Tseg1WDefault = 4;
  localparam int unsigned Tseg2WDefault = 3;

endpackage

// File: rtl/can_rx_sync.sv
// Two-flop synchronizer for the raw CAN RX pin plus recessive-to-dominant edge detect.
module can_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic rx_s_q, rx_s_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rx_i;
    rx_s_d = meta_q;
    prev_d = rx_s_q;
  end

  // Idle bus is recessive, so everything resets high to avoid a false edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      rx_s_q <= rx_s_d;
      prev_q <= prev_d;
    end
  end

  assign rx_s_o = rx_s_q;
  assign fall_o = prev_q & ~rx_s_q;

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit timing: prescaler, SYNC/SEG1/SEG2 sequencing, hard sync and resync.
module can_bit_timing
  import can_pkg::*;
#(
  parameter int unsigned BRP_W   = BrpWDefault,
  parameter int unsigned TSEG1_W = Tseg1WDefault,
  parameter int unsigned TSEG2_W = Tseg2WDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [BRP_W-1:0]   brp,
  input  logic [TSEG1_W-1:0] tseg1,
  input  logic [TSEG2_W-1:0] tseg2,
  input  logic [1:0]         sjw,
  input  logic               rx_in,
  input  logic               tx_bit,
  input  logic               tx_active,
  input  logic               hard_sync_en,
  output logic               can_tx,
  output logic               rx_bit,
  output logic               sample_stb,
  output logic               tx_stb,
  output logic               bit_err
);

  // One spare bit so SEG1 can be lengthened by up to four tq.
  localparam int unsigned CntW = ((TSEG1_W > TSEG2_W) ? TSEG1_W : TSEG2_W) + 1;
  localparam int unsigned SumW = CntW + 1;

  can_state_e state_q, state_d, st_e;
  logic [BRP_W-1:0]   presc_q, presc_d, presc_e, brp_q, brp_d;
  logic [TSEG1_W-1:0] tseg1_q, tseg1_d;
  logic [TSEG2_W-1:0] tseg2_q, tseg2_d;
  logic [1:0]         sjw_q, sjw_d;
  logic [CntW-1:0]    tq_cnt_q, tq_cnt_d, tq_e;
  logic [CntW-1:0]    seg_last_q, seg_last_d, last_e;
  logic [CntW-1:0]    sjw_p1, ext;
  logic [SumW-1:0]    late_sum;
  logic               can_tx_q, can_tx_d, rx_bit_q, rx_bit_d;
  logic               resync_done_q, resync_done_d;
  logic               rx_s, rx_fall, edge_ok, sync_taken, tq_stb, seg_done;

  can_rx_sync u_rx_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_i   (rx_in),
    .rx_s_o (rx_s),
    .fall_o (rx_fall)
  );

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    tq_cnt_d      = tq_cnt_q;
    seg_last_d    = seg_last_q;
    brp_d         = brp_q;
    tseg1_d       = tseg1_q;
    tseg2_d       = tseg2_q;
    sjw_d         = sjw_q;
    can_tx_d      = can_tx_q;
    rx_bit_d      = rx_bit_q;
    resync_done_d = resync_done_q;
    st_e          = state_q;
    presc_e       = presc_q;
    tq_e          = tq_cnt_q;
    last_e        = seg_last_q;
    sync_taken    = 1'b0;

    sjw_p1   = CntW'(sjw_q) + CntW'(1);
    ext      = (tq_cnt_q < CntW'(sjw_q)) ? tq_cnt_q + CntW'(1) : sjw_p1;
    late_sum = SumW'(tq_cnt_q) + SumW'(sjw_q);

    // Dominant edges we drive ourselves carry no timing information.
    edge_ok = rx_fall && (state_q != StIdle) && (state_q != StSync || hard_sync_en) &&
              !(tx_active && !can_tx_q) && !resync_done_q;

    // Synchronisation rewrites the view of the current cycle, then the normal advance applies.
    if (edge_ok && hard_sync_en) begin
      st_e       = StSeg1;
      presc_e    = '0;
      tq_e       = '0;
      last_e     = CntW'(tseg1_q);
      sync_taken = 1'b1;
    end else if (edge_ok && state_q == StSeg1) begin
      last_e     = seg_last_q + ext;
      sync_taken = 1'b1;
    end else if (edge_ok && state_q == StSeg2) begin
      sync_taken = 1'b1;
      if (SumW'(tseg2_q) <= late_sum) begin
        st_e    = StSeg1;
        presc_e = '0;
        tq_e    = '0;
        last_e  = CntW'(tseg1_q);
      end else begin
        last_e = seg_last_q - sjw_p1;
      end
    end

    tq_stb     = (presc_e == brp_q);
    seg_done   = tq_stb && (tq_e == last_e);
    sample_stb = (st_e == StSeg1) && seg_done;
    tx_stb     = (state_q == StSync) && (presc_q == '0);
    bit_err    = sample_stb && tx_active && (rx_s != can_tx_q);

    unique case (st_e)
      StIdle: begin
        if (enable) begin
          state_d    = StSync;
          presc_d    = '0;
          tq_cnt_d   = '0;
          seg_last_d = '0;
          brp_d      = brp;
          tseg1_d    = tseg1;
          tseg2_d    = tseg2;
          sjw_d      = sjw;
        end
      end
      StSync, StSeg1, StSeg2: begin
        state_d    = st_e;
        presc_d    = tq_stb ? '0 : presc_e + BRP_W'(1);
        tq_cnt_d   = tq_stb ? tq_e + CntW'(1) : tq_e;
        seg_last_d = last_e;
        if (seg_done) begin
          tq_cnt_d = '0;
          unique case (st_e)
            StSync: begin
              state_d    = StSeg1;
              seg_last_d = CntW'(tseg1_q);
            end
            StSeg1: begin
              state_d    = StSeg2;
              seg_last_d = CntW'(tseg2_q);
            end
            default: begin
              state_d    = StSync;
              seg_last_d = '0;
            end
          endcase
        end
      end
    endcase

    if (tx_stb) can_tx_d = tx_bit;
    if (sample_stb) rx_bit_d = rx_s;

    if (sync_taken) resync_done_d = 1'b1;
    else if (sample_stb) resync_done_d = 1'b0;

    if (!enable) begin
      state_d       = StIdle;
      presc_d       = '0;
      tq_cnt_d      = '0;
      seg_last_d    = '0;
      resync_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      presc_q       <= '0;
      tq_cnt_q      <= '0;
      seg_last_q    <= '0;
      brp_q         <= '0;
      tseg1_q       <= '0;
      tseg2_q       <= '0;
      sjw_q         <= '0;
      can_tx_q      <= 1'b1;
      rx_bit_q      <= 1'b1;
      resync_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      tq_cnt_q      <= tq_cnt_d;
      seg_last_q    <= seg_last_d;
      brp_q         <= brp_d;
      tseg1_q       <= tseg1_d;
      tseg2_q       <= tseg2_d;
      sjw_q         <= sjw_d;
      can_tx_q      <= can_tx_d;
      rx_bit_q      <= rx_bit_d;
      resync_done_q <= resync_done_d;
    end
  end

  assign can_tx = can_tx_q;
  assign rx_bit = rx_bit_q;

endmodule

// File: doc/can_bit_timing.md
CAN_BIT_TIMING -- requirements
Module: can_bit_timing

Interface
REQ-001 SHALL have parameter BRP_W, default 8, width of baud-rate prescaler.
REQ-002 SHALL have parameter TSEG1_W, default 4, width of tseg1 field.
REQ-003 SHALL have parameter TSEG2_W, default 3, width of tseg2 field.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port enable  in  1  1 = run bit timing, 0 = hold in IDLE.
REQ-007 SHALL have port brp  in  BRP_W  clocks per time quantum (tq) minus 1.
REQ-008 SHALL have ports tseg1 / tseg2 / sjw  in  TSEG1_W / TSEG2_W / 2  SEG1 tq-1, SEG2 tq-1, resync jump width tq-1.
REQ-009 SHALL have port rx_in  in  1  raw asynchronous CAN RX pin.
REQ-010 SHALL have ports tx_bit / tx_active / hard_sync_en  in  1 each  next bit to send; node transmitting; hard sync allowed (bus idle / SOF).
REQ-011 SHALL have ports can_tx / rx_bit  out  1 each  registered TX pin; last sampled bit.
REQ-012 SHALL have ports sample_stb / tx_stb / bit_err  out  1 each  one-cycle strobes.

Function
REQ-013 SHALL pass rx_in through two flops (rx_s); edge = rx_s 0 while previous rx_s 1 (recessive-to-dominant only).
REQ-014 SHALL latch brp/tseg1/tseg2/sjw when entering SYNC from IDLE; changes while enable=1 are ignored.
REQ-015 SHALL generate tq_stb when prescaler count == brp, then wrap count to 0.
REQ-016 SHALL sequence states IDLE -> SYNC (1 tq) -> SEG1 (tseg1+1 tq) -> SEG2 (tseg2+1 tq) -> SYNC; nominal bit = (brp+1)*(tseg1+tseg2+3) clocks.
REQ-017 SHALL leave IDLE for SYNC on the first clock with enable=1; enable=0 returns to IDLE next clock from any state.
REQ-018 SHALL assert tx_stb in the first clock of SYNC and load can_tx <= tx_bit at the end of that clock.
REQ-019 SHALL assert sample_stb in the last clock of SEG1 and load rx_bit <= rx_s at the end of that clock.
REQ-020 SHALL, on edge with hard_sync_en=1 in any non-IDLE state, make the edge cycle clock 0 of SEG1 tq 0 (prescaler and tq counter restart).
REQ-021 SHALL, on edge in SEG1 tq index k (hard_sync_en=0), lengthen SEG1 by min(k+1, sjw+1) tq.
REQ-022 SHALL, on edge in SEG2 with e = tseg2+1-k, end SEG2 and make edge cycle clock 0 of SEG1 (SYNC skipped) when e <= sjw+1; otherwise shorten SEG2 by sjw+1 tq.
REQ-023 SHALL ignore edges in SYNC, in IDLE, while tx_active=1 and can_tx=0, and after one resync/hard sync until the next sample_stb.
REQ-024 SHALL assert bit_err with sample_stb when tx_active=1 and rx_s != can_tx.
REQ-025 SHALL give hard sync priority over resync when both conditions hold.

Reset
REQ-026 SHALL, with rst_n=0 at a rising edge: state IDLE, counters 0, sync flops 1, can_tx 1, rx_bit 1, all strobes 0, resync flag clear.
REQ-027 SHALL abort any bit in progress on reset mid-bit with no strobe emitted after the reset edge.

Structure
REQ-028 SHALL place the state enum (IDLE, SYNC, SEG1, SEG2) and default widths in shared package can_pkg.
REQ-029 SHALL implement the synchronizer and edge detector as sub-module can_rx_sync; all else in one module.

Verification (brp=1, tseg1=5, tseg2=2, sjw=0 unless noted; bit = 20 clocks)
REQ-030 SHALL check free run, rx_in=1: tx_stb every 20 clocks, sample_stb 13 clocks after each tx_stb, rx_bit=1, bit_err=0.
REQ-031 SHALL check hard sync: hard_sync_en=1, rx_in falls at cycle 0 -> sample_stb at cycle 13, rx_bit=0 from cycle 14.
REQ-032 SHALL check positive resync: edge in SEG1 tq 2 -> that bit lasts 22 clocks, later bits 20; second edge same bit ignored.
REQ-033 SHALL check negative resync: sjw=3, edge in SEG2 tq 1 -> no tx_stb that bit, sample_stb 11 clocks after edge cycle.
REQ-034 SHALL check bit error: tx_active=1, tx_bit=1, rx_in=0 -> bit_err=1 exactly in sample_stb cycle.
REQ-035 SHALL check reset mid-SEG1: rst_n=0 one clock -> next cycle can_tx=1, rx_bit=1, strobes 0, next tx_stb 1 clock after rst_n=1.
